// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: PC width, counter encodings and the
// branch target table entry record.
package bp_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } counter_t;

    // Tag holds pc >> IDX_W, so its upper IDX_W bits are always zero.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        counter_t        counter;
    } entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating counter step: moves toward ST on taken, toward SNT on
// not taken, holding at either end.
module bp_sat_counter
    import bp_pkg::*;
(
    input  counter_t cnt,
    input  logic     taken,
    output counter_t next_cnt
);

    always_comb begin
        next_cnt = cnt;
        case (cnt)
            SNT: next_cnt = taken ? WNT : SNT;
            WNT: next_cnt = taken ? WT  : SNT;
            WT:  next_cnt = taken ? ST  : WNT;
            ST:  next_cnt = taken ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor with misprediction recovery.
// The table is built only when BRANCH_PRED_EN is defined; otherwise fetch always predicts pc+1.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] prePC,
    output logic            predTaken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_predTaken,
    input  logic [PC_W-1:0] upd_predPC,
    output logic            error,
    output logic [PC_W-1:0] newPC
);

    logic mispredict;

    // A taken branch is also wrong if it went somewhere other than the predicted PC.
    assign mispredict = (upd_taken != upd_predTaken) ||
                        (upd_taken && (upd_predPC != upd_target));
    assign error      = rst && upd_valid && mispredict;
    assign newPC      = upd_taken ? upd_target : pc_inc(upd_pc);

`ifdef BRANCH_PRED_EN

    localparam int ENTRIES = 2 ** IDX_W;

    entry_t          table_q [ENTRIES];
    logic [IDX_W-1:0] look_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [PC_W-1:0] look_tag;
    logic [PC_W-1:0] upd_tag;
    entry_t          look_entry;
    entry_t          upd_entry;
    logic            look_hit;
    logic            upd_hit;
    counter_t        upd_next;

    assign look_idx   = pc[IDX_W-1:0];
    assign upd_idx    = upd_pc[IDX_W-1:0];
    assign look_tag   = pc >> IDX_W;
    assign upd_tag    = upd_pc >> IDX_W;
    assign look_entry = table_q[look_idx];
    assign upd_entry  = table_q[upd_idx];
    assign look_hit   = look_entry.valid && (look_entry.tag == look_tag);
    assign upd_hit    = upd_entry.valid && (upd_entry.tag == upd_tag);

    bp_sat_counter u_sat_counter (
        .cnt      (upd_entry.counter),
        .taken    (upd_taken),
        .next_cnt (upd_next)
    );

    // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: WNT};
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                table_q[upd_idx].counter <= upd_next;
                if (upd_taken) begin
                    table_q[upd_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, counter: WT};
            end
        end
    end

    assign predTaken = look_hit && look_entry.counter[1];
    assign prePC     = predTaken ? look_entry.target : pc_inc(pc);

`else

    logic unused_clk;

    assign unused_clk = clk;
    assign predTaken  = 1'b0;
    assign prePC      = pc_inc(pc);

`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by random
// traffic, compared against a behavioural table model (honours BRANCH_PRED_EN).
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int NENT  = 16;
`ifdef BRANCH_PRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] prePC;
    logic        predTaken;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_predTaken;
    logic [15:0] upd_predPC;
    logic        error;
    logic [15:0] newPC;

    int errorCount = 0;
    int checkCount = 0;

    // Model: each slot remembers the full PC of the branch that owns it.
    logic        m_valid  [NENT];
    logic [15:0] m_owner  [NENT];
    logic [15:0] m_target [NENT];
    int          m_cnt    [NENT];

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .prePC         (prePC),
        .predTaken     (predTaken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_predTaken (upd_predTaken),
        .upd_predPC    (upd_predPC),
        .error         (error),
        .newPC         (newPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i]  = 1'b0;
            m_owner[i]  = 16'h0000;
            m_target[i] = 16'h0000;
            m_cnt[i]    = 1;
        end
    endtask

    function automatic bit modelHit(input logic [15:0] p);
        int slot = int'(p) % NENT;
        return m_valid[slot] && ((int'(m_owner[slot]) / NENT) == (int'(p) / NENT));
    endfunction

    function automatic logic modelPredTaken(input logic [15:0] p);
        int slot = int'(p) % NENT;
        return PRED_EN && modelHit(p) && (m_cnt[slot] >= 2);
    endfunction

    function automatic logic [15:0] modelPrePC(input logic [15:0] p);
        int slot = int'(p) % NENT;
        logic [15:0] seq = p + 16'd1;
        return modelPredTaken(p) ? m_target[slot] : seq;
    endfunction

    task automatic modelUpdate(input logic [15:0] upc, input logic ut, input logic [15:0] utg);
        int slot = int'(upc) % NENT;
        if (modelHit(upc)) begin
            m_cnt[slot] = ut ? ((m_cnt[slot] == 3) ? 3 : m_cnt[slot] + 1)
                             : ((m_cnt[slot] == 0) ? 0 : m_cnt[slot] - 1);
            if (ut) m_target[slot] = utg;
        end else if (ut) begin
            m_valid[slot]  = 1'b1;
            m_owner[slot]  = upc;
            m_target[slot] = utg;
            m_cnt[slot]    = 2;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [15:0] p, input logic uv,
                                 input logic [15:0] upc, input logic ut, input logic [15:0] utg,
                                 input logic upt, input logic [15:0] uppc);
        @(negedge clk);
        rst           = r;
        pc            = p;
        upd_valid     = uv;
        upd_pc        = upc;
        upd_taken     = ut;
        upd_target    = utg;
        upd_predTaken = upt;
        upd_predPC    = uppc;
    endtask

    // One cycle: drive at the falling edge, check just after, then let the table update.
    task automatic runCycle(input string tag, input logic r, input logic [15:0] p, input logic uv,
                            input logic [15:0] upc, input logic ut, input logic [15:0] utg,
                            input logic upt, input logic [15:0] uppc);
        logic exp_err;
        logic [15:0] exp_new;
        applyStimulus(r, p, uv, upc, ut, utg, upt, uppc);
        if (!r) modelReset();
        #1;
        exp_err = r && uv && ((ut != upt) || (ut && (uppc != utg)));
        exp_new = ut ? utg : upc + 16'd1;
        checkOutput({tag, ".predTaken"}, {15'b0, predTaken}, {15'b0, modelPredTaken(p)});
        checkOutput({tag, ".prePC"}, prePC, modelPrePC(p));
        checkOutput({tag, ".error"}, {15'b0, error}, {15'b0, exp_err});
        if (exp_err) checkOutput({tag, ".newPC"}, newPC, exp_new);
        @(posedge clk);
        if (r && uv) modelUpdate(upc, ut, utg);
    endtask

    logic [15:0] pool [8];

    initial begin
        modelReset();
        rst = 1'b0; pc = 16'h0; upd_valid = 1'b0; upd_pc = 16'h0; upd_taken = 1'b0;
        upd_target = 16'h0; upd_predTaken = 1'b0; upd_predPC = 16'h0;

        runCycle("reset", 1'b0, 16'h0010, 1'b1, 16'h0012, 1'b1, 16'h0040, 1'b0, 16'h0011);
        checkOutput("reset.const_prePC", prePC, 16'h0011);
        checkOutput("reset.const_error", {15'b0, error}, 16'h0000);

        runCycle("alloc", 1'b1, 16'h0010, 1'b1, 16'h0012, 1'b1, 16'h0040, 1'b0, 16'h0013);
        checkOutput("alloc.const_error", {15'b0, error}, 16'h0001);
        checkOutput("alloc.const_newPC", newPC, 16'h0040);
        runCycle("hit", 1'b1, 16'h0012, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);

        runCycle("nt1", 1'b1, 16'h0012, 1'b1, 16'h0012, 1'b0, 16'h0, modelPredTaken(16'h0012), modelPrePC(16'h0012));
        runCycle("nt2", 1'b1, 16'h0012, 1'b1, 16'h0012, 1'b0, 16'h0, modelPredTaken(16'h0012), modelPrePC(16'h0012));
        runCycle("tk3", 1'b1, 16'h0012, 1'b1, 16'h0012, 1'b1, 16'h0040, 1'b0, 16'h0013);
        runCycle("wnt", 1'b1, 16'h0012, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("wnt.const_prePC", prePC, 16'h0013);

        runCycle("alias", 1'b1, 16'h0012, 1'b1, 16'h0022, 1'b1, 16'h0080, 1'b0, 16'h0023);
        runCycle("evicted", 1'b1, 16'h0012, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("evicted.const_prePC", prePC, 16'h0013);
        runCycle("owner", 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);

        runCycle("retarget", 1'b1, 16'h0022, 1'b1, 16'h0022, 1'b1, 16'h0050, 1'b1, 16'h0040);
        checkOutput("retarget.const_error", {15'b0, error}, 16'h0001);
        checkOutput("retarget.const_newPC", newPC, 16'h0050);
        runCycle("newtgt", 1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);

        runCycle("wrap", 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234);
        checkOutput("wrap.const_prePC", prePC, 16'h0000);
        checkOutput("wrap.const_error", {15'b0, error}, 16'h0001);
        checkOutput("wrap.const_newPC", newPC, 16'h0000);

        pool = '{16'h0012, 16'h0022, 16'hFFFF, 16'h0103, 16'h0113, 16'h1005, 16'hFFF5, 16'h0000};
        for (int n = 0; n < 400; n++) begin
            logic [15:0] p_r, upc_r, tgt_r, uppc_r;
            logic        r_r, uv_r, ut_r, upt_r;
            p_r   = ($urandom_range(0, 7) == 7) ? 16'($urandom) : pool[$urandom_range(0, 6)];
            upc_r = ($urandom_range(0, 7) == 7) ? 16'($urandom) : pool[$urandom_range(0, 6)];
            r_r   = ($urandom_range(0, 49) != 0);
            uv_r  = ($urandom_range(0, 3) != 0);
            ut_r  = $urandom_range(0, 1);
            tgt_r = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                upt_r  = modelPredTaken(upc_r);
                uppc_r = modelPrePC(upc_r);
            end else begin
                upt_r  = $urandom_range(0, 1);
                uppc_r = ($urandom_range(0, 1) == 0) ? tgt_r : 16'($urandom);
            end
            runCycle("rand", r_r, p_r, uv_r, upc_r, ut_r, tgt_r, upt_r, uppc_r);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
